axi_serial_responder: RTL

- AXI4 subordinate endpoint that terminates the ID-serialized, in-order manager port of the interconnect and bridges it onto a single-port word-addressed memory interface.
- Handles one transaction at a time, either read or write, and generates one memory access per data beat.
- Echoes the request ID in B and R, and answers unsupported requests with SLVERR.
- Sits behind the ID serializer in front of SRAM macros and register banks.

---
 rtl/axi_serial_responder.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_serial_responder.sv
// In-order AXI4 subordinate that serves one transaction at a time on a single-port word memory.
// Optional build macro AXI_SERIAL_RESPONDER_ERR_CNT_EN adds the saturating SLVERR counter err_cnt_o.
package axi_serial_responder_pkg;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 1;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned UserWidth = 1;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [5:0]           atop;
  } aw_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ar_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module axi_serial_responder #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 1,
  parameter type         req_t     = axi_serial_responder_pkg::req_t,
  parameter type         resp_t    = axi_serial_responder_pkg::resp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  req_t                   slv_req_i,
  output resp_t                  slv_resp_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_strb_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i
`ifdef AXI_SERIAL_RESPONDER_ERR_CNT_EN
  ,
  output logic [15:0]            err_cnt_o
`endif
);

  localparam int unsigned StrbWidth  = DataWidth / 8;
  localparam int unsigned OffWidth   = $clog2(StrbWidth);
  localparam int unsigned CntWidth   = 9;
  localparam logic [2:0]  MaxSize    = 3'(OffWidth);
  localparam logic [1:0]  BurstFixed = 2'b00;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic [2:0] {
    Idle, WrData, WrResp, RdMem, RdWait, RdResp
  } state_e;

  state_e                 state_q, state_d;
  logic                   rd_prio_q, rd_prio_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [2:0]             size_q, size_d;
  logic [1:0]             burst_q, burst_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   last_err_q, last_err_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;

  logic                   aw_err, ar_err;
  logic                   take_aw, take_ar;
  logic                   cnt_one;
  logic [AddrWidth-1:0]   beat_bytes, addr_next;

  // WRAP and reserved bursts both have burst[1] set
  assign aw_err = (slv_req_i.aw.atop != '0) | slv_req_i.aw.burst[1] |
                  (slv_req_i.aw.size > MaxSize);
  assign ar_err = slv_req_i.ar.burst[1] | (slv_req_i.ar.size > MaxSize);

  assign cnt_one    = (cnt_q == CntWidth'(1));
  assign beat_bytes = AddrWidth'(1) << size_q;
  assign addr_next  = (burst_q == BurstFixed) ? addr_q
                    : ((addr_q & ~(beat_bytes - AddrWidth'(1))) + beat_bytes);
  assign mem_addr_o = addr_q & ~AddrWidth'(StrbWidth - 1);

  // State and transaction registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= Idle;
      rd_prio_q  <= 1'b1;
      id_q       <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      last_err_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_prio_q  <= rd_prio_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      last_err_q <= last_err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next state, handshakes and memory request
  always_comb begin
    state_d     = state_q;
    rd_prio_d   = rd_prio_q;
    id_d        = id_q;
    addr_d      = addr_q;
    size_d      = size_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    last_err_d  = last_err_q;
    rdata_d     = rdata_q;
    take_aw     = 1'b0;
    take_ar     = 1'b0;
    slv_resp_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_strb_o  = '0;

    unique case (state_q)
      Idle: begin
        take_ar = slv_req_i.ar_valid & (~slv_req_i.aw_valid | rd_prio_q);
        take_aw = slv_req_i.aw_valid & ~take_ar;
        if (slv_req_i.aw_valid & slv_req_i.ar_valid) rd_prio_d = ~take_ar;
        slv_resp_o.aw_ready = take_aw;
        slv_resp_o.ar_ready = take_ar;
        if (take_aw) begin
          id_d       = IdWidth'(slv_req_i.aw.id);
          addr_d     = AddrWidth'(slv_req_i.aw.addr);
          size_d     = slv_req_i.aw.size;
          burst_d    = slv_req_i.aw.burst;
          cnt_d      = CntWidth'(slv_req_i.aw.len) + CntWidth'(1);
          err_d      = aw_err;
          last_err_d = 1'b0;
          state_d    = WrData;
        end else if (take_ar) begin
          id_d       = IdWidth'(slv_req_i.ar.id);
          addr_d     = AddrWidth'(slv_req_i.ar.addr);
          size_d     = slv_req_i.ar.size;
          burst_d    = slv_req_i.ar.burst;
          cnt_d      = CntWidth'(slv_req_i.ar.len) + CntWidth'(1);
          err_d      = ar_err;
          last_err_d = 1'b0;
          rdata_d    = '0;
          state_d    = ar_err ? RdResp : RdMem;
        end
      end

      WrData: begin
        if (err_q) begin
          slv_resp_o.w_ready = 1'b1;
        end else begin
          mem_req_o          = slv_req_i.w_valid;
          mem_we_o           = 1'b1;
          mem_wdata_o        = DataWidth'(slv_req_i.w.data);
          mem_strb_o         = StrbWidth'(slv_req_i.w.strb);
          slv_resp_o.w_ready = slv_req_i.w_valid & mem_gnt_i;
        end
        if (slv_req_i.w_valid & slv_resp_o.w_ready) begin
          cnt_d  = cnt_q - CntWidth'(1);
          addr_d = addr_next;
          // last must coincide with the final counted beat
          if (slv_req_i.w.last != cnt_one) last_err_d = 1'b1;
          if (slv_req_i.w.last | cnt_one) state_d = WrResp;
        end
      end

      WrResp: begin
        slv_resp_o.b_valid = 1'b1;
        slv_resp_o.b.id    = id_q;
        slv_resp_o.b.resp  = (err_q | last_err_q) ? RespSlvErr : RespOkay;
        if (slv_req_i.b_ready) state_d = Idle;
      end

      RdMem: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = RdWait;
      end

      RdWait: begin
        if (mem_rvalid_i) begin
          rdata_d = mem_rdata_i;
          state_d = RdResp;
        end
      end

      RdResp: begin
        slv_resp_o.r_valid = 1'b1;
        slv_resp_o.r.id    = id_q;
        slv_resp_o.r.data  = rdata_q;
        slv_resp_o.r.resp  = err_q ? RespSlvErr : RespOkay;
        slv_resp_o.r.last  = cnt_one;
        if (slv_req_i.r_ready) begin
          cnt_d = cnt_q - CntWidth'(1);
          if (cnt_one) begin
            state_d = Idle;
          end else begin
            addr_d  = addr_next;
            state_d = err_q ? RdResp : RdMem;
          end
        end
      end

      default: state_d = Idle;
    endcase
  end

`ifdef AXI_SERIAL_RESPONDER_ERR_CNT_EN
  logic        err_evt;
  logic [15:0] err_cnt_q;

  assign err_evt = ((state_q == WrResp) & slv_req_i.b_ready & (err_q | last_err_q)) |
                   ((state_q == RdResp) & slv_req_i.r_ready & err_q & cnt_one);

  // Saturating count of completed SLVERR responses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (err_evt && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule
